// File: rtl/fetch_pc_gen_pkg.sv
// Shared types and defaults for the fetch PC generator: address type, control
// states, next-PC select encoding and the alignment check.
package fetch_pc_gen_pkg;

  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } pcgen_state_t;

  typedef enum logic [1:0] {
    SEL_HOLD     = 2'd0,
    SEL_SEQ      = 2'd1,
    SEL_REDIRECT = 2'd2,
    SEL_TRAP     = 2'd3
  } pc_sel_t;

  localparam int unsigned INSTR_BYTES_DEFAULT = 32'd4;
  localparam addr_t       RESET_VEC_DEFAULT   = 32'h8000_0000;

  function automatic logic addr_misaligned(input addr_t addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_gen_pc_redirect_arb.sv
// Combinational next-PC priority select (trap > redirect > sequential) and
// misaligned-target detection.
module pc_redirect_arb
  import fetch_pc_gen_pkg::*;
#(
  parameter int unsigned INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
  input  logic    trap_valid_i,
  input  addr_t   trap_vector_i,
  input  logic    redirect_valid_i,
  input  addr_t   redirect_target_i,
  input  logic    accept_i,
  input  addr_t   pc_i,
  output addr_t   next_pc_o,
  output pc_sel_t sel_o,
  output logic    misaligned_o
);

  // Priority select; a misaligned redirect keeps the current PC
  always_comb begin
    next_pc_o    = pc_i;
    sel_o        = SEL_HOLD;
    misaligned_o = 1'b0;
    if (trap_valid_i) begin
      next_pc_o = trap_vector_i;
      sel_o     = SEL_TRAP;
    end else if (redirect_valid_i) begin
      sel_o = SEL_REDIRECT;
      if (addr_misaligned(redirect_target_i)) begin
        misaligned_o = 1'b1;
      end else begin
        next_pc_o = redirect_target_i;
      end
    end else if (accept_i) begin
      next_pc_o = pc_i + addr_t'(INSTR_BYTES);
      sel_o     = SEL_SEQ;
    end else begin
      next_pc_o = pc_i;
      sel_o     = SEL_HOLD;
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Program-counter generator feeding the fetch stage: sequential issue, branch
// redirects, trap entry, halt handling and misaligned-target fault capture.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter addr_t       RESET_VEC   = RESET_VEC_DEFAULT,
  parameter int unsigned INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_data_o,
  output logic        pc_valid_o,
  input  logic        pc_ready_i,
  output logic        flush_o,
  input  logic        halt_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  input  logic        trap_valid_i,
  input  logic [31:0] trap_vector_i,
  output logic        fault_valid_o,
  output logic [31:0] fault_addr_o,
  input  logic        fault_ack_i,
  output logic [31:0] issued_cnt_o
);

  pcgen_state_t state_q, state_d;
  addr_t        pc_q, pc_d;
  logic         offered_q, offered_d;
  logic [31:0]  cnt_q, cnt_d;
  addr_t        fault_addr_q, fault_addr_d;

  logic    pc_valid_s, accept_s, redir_en_s, misaligned_s, flush_s;
  addr_t   next_pc_s;
  pc_sel_t sel_s;

  // An offered PC stays valid through halt until it is accepted
  assign pc_valid_s = !rst && (state_q == ST_RUN) && (!halt_i || offered_q);
  assign accept_s   = pc_valid_s && pc_ready_i;
  assign redir_en_s = redirect_valid_i && (state_q != ST_FAULT);

  pc_redirect_arb #(
    .INSTR_BYTES(INSTR_BYTES)
  ) u_arb (
    .trap_valid_i     (trap_valid_i),
    .trap_vector_i    (trap_vector_i),
    .redirect_valid_i (redir_en_s),
    .redirect_target_i(redirect_target_i),
    .accept_i         (accept_s),
    .pc_i             (pc_q),
    .next_pc_o        (next_pc_s),
    .sel_o            (sel_s),
    .misaligned_o     (misaligned_s)
  );

  // Next-state and flush decode
  always_comb begin
    state_d      = state_q;
    pc_d         = next_pc_s;
    offered_d    = offered_q;
    cnt_d        = cnt_q + 32'(accept_s);
    fault_addr_d = fault_addr_q;
    flush_s      = 1'b0;
    case (sel_s)
      SEL_TRAP: begin
        state_d   = ST_RUN;
        offered_d = 1'b0;
        flush_s   = 1'b1;
      end
      SEL_REDIRECT: begin
        offered_d = 1'b0;
        flush_s   = 1'b1;
        if (misaligned_s) begin
          state_d      = ST_FAULT;
          fault_addr_d = redirect_target_i;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        case (state_q)
          ST_RUN: begin
            offered_d = pc_valid_s && !pc_ready_i;
            if (halt_i && (!offered_q || accept_s)) begin
              state_d = ST_HALTED;
            end else begin
              state_d = ST_RUN;
            end
          end
          ST_HALTED: begin
            offered_d = 1'b0;
            if (!halt_i) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_HALTED;
            end
          end
          ST_FAULT: begin
            offered_d = 1'b0;
            if (fault_ack_i) begin
              state_d = ST_HALTED;
            end else begin
              state_d = ST_FAULT;
            end
          end
          default: begin
            state_d   = ST_RUN;
            offered_d = 1'b0;
          end
        endcase
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_VEC;
      offered_q    <= 1'b0;
      cnt_q        <= 32'd0;
      fault_addr_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      offered_q    <= offered_d;
      cnt_q        <= cnt_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign pc_data_o     = pc_q;
  assign pc_valid_o    = pc_valid_s;
  assign flush_o       = flush_s && !rst;
  assign fault_valid_o = (state_q == ST_FAULT);
  assign fault_addr_o  = (state_q == ST_FAULT) ? fault_addr_q : 32'd0;
  assign issued_cnt_o  = cnt_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: expected accepted PCs go into a scoreboard
// queue checked by an independent monitor; control outputs are checked inline.
module tb_fetch_pc_gen;

  logic        clk;
  logic        rst;
  logic [31:0] pc_data;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        fault_valid;
  logic [31:0] fault_addr;
  logic        fault_ack;
  logic [31:0] issued_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  fetch_pc_gen dut (
    .clk              (clk),
    .rst              (rst),
    .pc_data_o        (pc_data),
    .pc_valid_o       (pc_valid),
    .pc_ready_i       (pc_ready),
    .flush_o          (flush),
    .halt_i           (halt),
    .redirect_valid_i (redirect_valid),
    .redirect_target_i(redirect_target),
    .trap_valid_i     (trap_valid),
    .trap_vector_i    (trap_vector),
    .fault_valid_o    (fault_valid),
    .fault_addr_o     (fault_addr),
    .fault_ack_i      (fault_ack),
    .issued_cnt_o     (issued_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted PC must match the next expected one
  always @(negedge clk) begin
    if (!rst && pc_valid && pc_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL accept_unexpected: got %h expected none", pc_data);
      end else begin
        chk("accept_pc", pc_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; pc_ready = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'd0; trap_valid = 1'b0; trap_vector = 32'd0; fault_ack = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_pc", pc_data, 32'h8000_0000);
    chk("rst_valid", {31'd0, pc_valid}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_fault_valid", {31'd0, fault_valid}, 32'd0);
    chk("rst_fault_addr", fault_addr, 32'd0);
    chk("rst_cnt", issued_cnt, 32'd0);
    step();
    rst = 1'b0; pc_ready = 1'b1;

    // Back-to-back sequential issue
    exp_q.push_back(32'h8000_0000);
    @(negedge clk); chk("first_valid", {31'd0, pc_valid}, 32'd1); step();
    exp_q.push_back(32'h8000_0004); step();
    exp_q.push_back(32'h8000_0008); step();
    pc_ready = 1'b0;
    @(negedge clk);
    chk("seq_cnt", issued_cnt, 32'd3);
    chk("seq_pc", pc_data, 32'h8000_000C);

    // Asynchronous reset mid-operation
    #1 rst = 1'b1;
    #1;
    chk("arst_pc", pc_data, 32'h8000_0000);
    chk("arst_cnt", issued_cnt, 32'd0);
    chk("arst_valid", {31'd0, pc_valid}, 32'd0);
    step();
    rst = 1'b0;

    // Stall with halt raised: offered PC must be held until accepted
    @(negedge clk); chk("stall_valid", {31'd0, pc_valid}, 32'd1); step();
    halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("halt_hold_valid", {31'd0, pc_valid}, 32'd1);
      chk("halt_hold_pc", pc_data, 32'h8000_0000);
      step();
    end
    pc_ready = 1'b1;
    exp_q.push_back(32'h8000_0000);
    step();
    pc_ready = 1'b0;
    @(negedge clk);
    chk("halted_valid", {31'd0, pc_valid}, 32'd0);
    chk("halted_cnt", issued_cnt, 32'd1);
    step();
    halt = 1'b0;
    @(negedge clk); chk("unhalt_valid", {31'd0, pc_valid}, 32'd0); step();

    // Redirect coinciding with an accept
    pc_ready = 1'b1;
    exp_q.push_back(32'h8000_0004); step();
    exp_q.push_back(32'h8000_0008); step();
    exp_q.push_back(32'h8000_000C); step();
    redirect_valid = 1'b1; redirect_target = 32'h8000_0100;
    exp_q.push_back(32'h8000_0010);
    @(negedge clk); chk("redir_flush", {31'd0, flush}, 32'd1); step();
    redirect_valid = 1'b0;
    exp_q.push_back(32'h8000_0100);
    @(negedge clk);
    chk("redir_flush_once", {31'd0, flush}, 32'd0);
    chk("redir_cnt", issued_cnt, 32'd5);
    step();

    // Misaligned redirect, ignored redirect in fault, ack with trap
    pc_ready = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h8000_0102;
    @(negedge clk);
    chk("mis_flush", {31'd0, flush}, 32'd1);
    chk("mis_pc", pc_data, 32'h8000_0104);
    step();
    redirect_target = 32'h8000_0200;
    @(negedge clk);
    chk("fault_valid", {31'd0, fault_valid}, 32'd1);
    chk("fault_addr", fault_addr, 32'h8000_0102);
    chk("fault_pc_valid", {31'd0, pc_valid}, 32'd0);
    chk("fault_redir_ignored", {31'd0, flush}, 32'd0);
    step();
    redirect_valid = 1'b0; fault_ack = 1'b1; trap_valid = 1'b1; trap_vector = 32'h8000_0400;
    @(negedge clk); chk("ack_trap_flush", {31'd0, flush}, 32'd1); step();
    fault_ack = 1'b0; trap_valid = 1'b0; pc_ready = 1'b1;
    exp_q.push_back(32'h8000_0400);
    @(negedge clk); chk("ack_fault_clear", {31'd0, fault_valid}, 32'd0); step();

    // Fault acknowledged without trap parks in HALTED
    pc_ready = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h8000_0003;
    @(negedge clk); chk("mis2_flush", {31'd0, flush}, 32'd1); step();
    redirect_valid = 1'b0; fault_ack = 1'b1;
    @(negedge clk); chk("mis2_fault", {31'd0, fault_valid}, 32'd1); step();
    fault_ack = 1'b0; halt = 1'b1;
    @(negedge clk);
    chk("ack_halted_fault", {31'd0, fault_valid}, 32'd0);
    chk("ack_halted_valid", {31'd0, pc_valid}, 32'd0);
    step();
    halt = 1'b0;
    @(negedge clk); chk("ack_unhalt_valid", {31'd0, pc_valid}, 32'd0); step();
    @(negedge clk); chk("ack_resume_pc", pc_data, 32'h8000_0404); step();

    // Trap and redirect together: trap wins
    trap_valid = 1'b1; trap_vector = 32'h8000_0800;
    redirect_valid = 1'b1; redirect_target = 32'h8000_0200;
    @(negedge clk); chk("prio_flush", {31'd0, flush}, 32'd1); step();
    trap_valid = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    chk("prio_flush_once", {31'd0, flush}, 32'd0);
    chk("prio_pc", pc_data, 32'h8000_0800);
    step();

    // Address wrap
    trap_valid = 1'b1; trap_vector = 32'hFFFF_FFFC; step();
    trap_valid = 1'b0; pc_ready = 1'b1;
    exp_q.push_back(32'hFFFF_FFFC); step();
    exp_q.push_back(32'h0000_0000); step();
    pc_ready = 1'b0;
    @(negedge clk);
    chk("wrap_cnt", issued_cnt, 32'd9);
    chk("wrap_pc", pc_data, 32'h0000_0004);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Program-counter generator sitting directly upstream of the instruction-fetch stage. It drives the fetch stage's `pc` decoupled input with sequential word addresses, and applies branch redirects and trap vectors from the back end. It raises the one-cycle `flush` to fetch on every redirect and holds the front end in a fault state on a misaligned redirect target until software-visible acknowledgement.

## Interface
Parameters:
- `RESET_VEC`, `32'h8000_0000`: PC presented after reset.
- `INSTR_BYTES`, `4`: sequential increment.

Ports (reset rst, asynchronous, active-high; clock clk):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `pc`  decoupled.out  32  fetch address to fetch stage (`pc.data`, `pc.valid`, `pc.ready`)
- `flush`  out  1  one-cycle squash to fetch stage
- `halt`  in  1  stop issuing new PCs (level)
- `redirect_valid`  in  1  taken branch/jump resolved
- `redirect_target`  in  32  branch target
- `trap_valid`  in  1  exception/interrupt entry
- `trap_vector`  in  32  trap handler address
- `fault_valid`  out  1  misaligned redirect target pending
- `fault_addr`  out  32  offending target
- `fault_ack`  in  1  clears fault; resume at `trap_vector` if `trap_valid`, else halted
- `issued_cnt`  out  32  count of accepted PCs (perf)

## Operation
- States: `RUN`, `HALTED`, `FAULT`.
- Registers: `pc_q` (32), `offered` (PC shown with valid, not yet accepted), `issued_cnt`, `fault_addr_q`.
- `pc.data = pc_q`. `pc.valid = (state==RUN) && (!halt || offered)`.
- Stability: once `pc.valid` rises, `pc.data` and `pc.valid` hold until `pc.ready` or a redirect/trap. `halt` never drops an offered PC.
- Accept (`pc.valid && pc.ready`, no redirect/trap): `pc_q <= pc_q + INSTR_BYTES`, mod 2^32 (wraps `FFFF_FFFC -> 0000_0000`). Clear `offered`; `issued_cnt++` (wraps).
- Redirect priority, high to low: `trap_valid`, `redirect_valid`, accept.
- `trap_valid` in any state: `pc_q <= trap_vector`, state `RUN`, `flush=1` that cycle, clear `offered`, clear fault.
- `redirect_valid` in `RUN`/`HALTED`:
  - `flush=1` the same cycle (combinational).
  - Target aligned (`[1:0]==0`): `pc_q <= target`, clear `offered`, state unchanged.
  - Target misaligned: `fault_addr_q <= target`, state `FAULT`.
- An accept coinciding with a redirect/trap still increments `issued_cnt`, but the +4 is discarded.
- `HALTED`: entered from `RUN` when `halt && !offered` (or `halt` with accept the same cycle). Return to `RUN` when `!halt`.
- `FAULT`:
  - `pc.valid=0`, `fault_valid=1`, `fault_addr=fault_addr_q`; `redirect_valid` is ignored.
  - `fault_ack` without a trap moves to `HALTED`.

## Timing
- Reset values: `pc.data=RESET_VEC`, `pc.valid=0` while `rst`, `flush=0`, `fault_valid=0`, `fault_addr=0`, `issued_cnt=0`, state `RUN`, `offered=0`.
- First cycle after reset deassert: `pc.valid=1` with `RESET_VEC` (unless `halt`).
- Accept to next PC: 1 cycle (back-to-back PCs possible if fetch is ready every cycle).
- Redirect/trap to new PC valid: 1 cycle.
- `flush` is exactly the redirect/trap cycle, never registered, never two cycles for one event.
- Redirect while fetch is waiting on memory: `flush` squashes it. The new PC is offered the next cycle even though fetch may still be draining a stale response.
- Reset mid-operation: all state returns to reset values asynchronously; no `flush` is emitted.

## Structure
- Shared package `types.sv`:
  - `addr_t` (32-bit).
  - `pcgen_state_t` enum.
  - `INSTR_BYTES` default constant.
- One natural sub-module: `pc_redirect_arb` (combinational priority select of trap/redirect/sequential next-PC, plus the misalignment check).
- Everything else lives in `fetch_pc_gen`.

## Test plan
- Reset release, ready=1 constantly: `pc.data` = 8000_0000, 8000_0004, 8000_0008 on consecutive cycles; `issued_cnt`=3 after 3 cycles.
- Ready=0 for 5 cycles with `halt` raised in cycle 2: `pc.valid`/`pc.data` stay 8000_0000 until ready. After accept, `pc.valid=0` and state `HALTED`.
- `redirect_valid` with 8000_0100 in the same cycle as accept of 8000_0010: `flush=1` for one cycle, next `pc.data`=8000_0100, `issued_cnt` incremented.
- Redirect to 8000_0102: `flush=1`, `fault_valid=1`, `fault_addr`=8000_0102, `pc.valid=0`. `fault_ack` with `trap_valid`, `trap_vector`=8000_0400 gives `pc.data`=8000_0400 next cycle.
- `trap_valid` and `redirect_valid` in the same cycle: trap wins, `pc.data`=`trap_vector`, single `flush` pulse.
- `pc_q`=FFFF_FFFC accepted: next `pc.data`=0000_0000.
